// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns, bus bit positions, capture FSM states.
// Latency: none (constants only).
// Backpressure: not applicable.
package seven_seg_pkg;

    // Active-low {a,b,c,d,e,f,g} patterns as driven by the encoder side.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0001100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Positions on the 8-bit seg_n bus: a..g occupy [7:1], dp is [0].
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Capture FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

endpackage

// File: rtl/seg_pattern_to_hex.sv
// Inverse of the hex-to-segment encoder: 7-bit active-low pattern to nibble, err on unknown glyph.
// Latency: combinational.
// Backpressure: none.
module seg_pattern_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    // Table lookup; anything outside the 16 glyphs decodes to 0 with err.
    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Read-back monitor: samples the multiplexed display bus and rebuilds one full scan frame as a hex word.
// Latency: a digit stable for STABLE_CYCLES samples is captured; frame_valid follows the last capture by one cycle.
// Backpressure: none; passive observer, capture_en low aborts the current frame.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_en,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [7:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   samp_an, prev_an;
    logic [7:0]              samp_seg, prev_seg;
    logic [1:0]              state, nxt_state;
    logic [CNT_W-1:0]        cnt, nxt_cnt;
    logic [NUM_DIGITS-1:0]   mask, nxt_mask;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp, shadow_err;

    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic                    sel_valid;
    logic [IDX_W-1:0]        sel_idx;
    logic                    changed;
    logic                    capture;
    logic                    complete;
    logic [3:0]              dec_nibble;
    logic                    dec_err;

    seg_pattern_to_hex u_dec (
        .pattern (samp_seg[SEG_A_BIT:SEG_G_BIT]),
        .nibble  (dec_nibble),
        .err     (dec_err)
    );

    // Sample stage plus one-deep history used for the stability comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_an  <= '1;
            prev_an  <= '1;
            samp_seg <= '1;
            prev_seg <= '1;
        end else begin
            samp_an  <= an_n;
            prev_an  <= samp_an;
            samp_seg <= seg_n;
            prev_seg <= samp_seg;
        end
    end

    // Digit select: exactly one anode low; index of that anode.
    always_comb begin
        sel_onehot = ~samp_an;
        sel_valid  = (sel_onehot != '0) &&
                     ((sel_onehot & (sel_onehot - NUM_DIGITS'(1))) == '0);
        sel_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_onehot[i]) sel_idx = IDX_W'(i);
        end
        changed = (samp_an != prev_an) || (samp_seg != prev_seg);
    end

    // FSM next state and settle counter; capture fires on the cycle the count reaches the target.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        capture   = 1'b0;
        if (!capture_en) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        nxt_state = ST_SETTLE;
                        nxt_cnt   = CNT_W'(1);
                    end else begin
                        nxt_cnt   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (!sel_valid) begin
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end else if (changed) begin
                        nxt_cnt   = CNT_W'(1);
                    end else if (cnt != CNT_TGT) begin
                        nxt_cnt   = cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (changed) begin
                        if (sel_valid) begin
                            nxt_state = ST_SETTLE;
                            nxt_cnt   = CNT_W'(1);
                        end else begin
                            nxt_state = ST_IDLE;
                            nxt_cnt   = '0;
                        end
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end
            endcase
            if (nxt_state == ST_SETTLE && nxt_cnt == CNT_TGT) begin
                capture   = 1'b1;
                nxt_state = ST_HELD;
            end
        end
    end

    // Frame completion clears the mask first; a same-cycle capture lands in the new frame.
    always_comb begin
        complete = (&mask) && !frame_valid;
        nxt_mask = complete ? '0 : mask;
        if (!capture_en) begin
            nxt_mask = '0;
        end else if (capture) begin
            nxt_mask = nxt_mask | sel_onehot;
        end
    end

    // FSM, counter and seen-mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            mask  <= nxt_mask;
        end
    end

    // Shadow slots: a recapture of the same digit simply overwrites.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            shadow_err <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    shadow_val[4*i +: 4] <= dec_nibble;
                    shadow_dp[i]         <= ~samp_seg[SEG_DP_BIT];
                    shadow_err[i]        <= dec_err;
                end
            end
        end
    end

    // Publish a complete frame; outputs hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_out   <= '0;
            dp_out      <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= complete;
            if (complete) begin
                value_out <= shadow_val;
                dp_out    <= shadow_dp;
                err_out   <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_en;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_out;
    logic        frame_valid;

    int   vectors     = 0;
    int   miscompares = 0;
    int   fv_cnt      = 0;
    int   fv_base     = 0;
    logic fv_prev     = 1'b0;

    logic [6:0] pat [16];

    seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .value_out   (value_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse counter and back-to-back guard, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            check("fv_not_back_to_back", {31'b0, fv_prev}, 32'd0);
        end
        fv_prev = frame_valid;
    end

    task automatic show_raw(input int idx, input logic [7:0] seg, input int cycles);
        an_n  = ~(4'b0001 << idx);
        seg_n = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic show(input int idx, input logic [3:0] hexv, input logic dp, input int cycles);
        show_raw(idx, {pat[hexv], ~dp}, cycles);
    endtask

    task automatic idle(input int cycles);
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dps, input int cycles);
        for (int i = 0; i < 4; i++) show(i, v[4*i +: 4], dps[i], cycles);
    endtask

    initial begin
        pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
        pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0001100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
        pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;

        rst = 1'b1; capture_en = 1'b1; an_n = 4'hF; seg_n = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_value", value_out, 32'h0);
        check("rst_dp", dp_out, 32'h0);
        check("rst_err", err_out, 32'h0);
        check("rst_fv", frame_valid, 32'h0);
        check("rst_state", dut.state, 32'h0);
        check("rst_mask", dut.mask, 32'h0);
        check("rst_cnt", dut.cnt, 32'h0);

        // Basic scan 1,2,3,4
        fv_base = fv_cnt;
        scan(16'h4321, 4'b0000, 64);
        idle(4);
        check("scan1_fv_count", fv_cnt - fv_base, 32'd1);
        check("scan1_value", value_out, 32'h4321);
        check("scan1_err", err_out, 32'h0);
        check("scan1_dp", dp_out, 32'h0);

        // Last digit held one cycle short, then exactly long enough
        fv_base = fv_cnt;
        show(0, 4'h8, 1'b0, 64);
        show(1, 4'h9, 1'b0, 64);
        show(2, 4'hE, 1'b0, 64);
        show(3, 4'h5, 1'b0, 15);
        idle(4);
        check("short_fv_count", fv_cnt - fv_base, 32'd0);
        check("short_mask", dut.mask, 32'h7);
        check("short_value_held", value_out, 32'h4321);
        show(3, 4'h5, 1'b0, 16);
        idle(4);
        check("exact_fv_count", fv_cnt - fv_base, 32'd1);
        check("exact_value", value_out, 32'h5E98);

        // Blank digit 2 is undecodable
        fv_base = fv_cnt;
        show(0, 4'h5, 1'b0, 64);
        show(1, 4'h6, 1'b0, 64);
        show_raw(2, 8'hFF, 64);
        show(3, 4'h7, 1'b0, 64);
        idle(4);
        check("blank_fv_count", fv_cnt - fv_base, 32'd1);
        check("blank_value", value_out, 32'h7065);
        check("blank_err", err_out, 32'h4);
        check("blank_dp", dp_out, 32'h0);

        // Decimal point on digit 0 with F
        fv_base = fv_cnt;
        scan(16'h321F, 4'b0001, 64);
        idle(4);
        check("dp_fv_count", fv_cnt - fv_base, 32'd1);
        check("dp_value", value_out, 32'h321F);
        check("dp_dp", dp_out, 32'h1);
        check("dp_err", err_out, 32'h0);

        // capture_en low aborts the partial frame, outputs kept
        show(0, 4'hA, 1'b0, 64);
        show(1, 4'hB, 1'b0, 64);
        check("en_mask_before", dut.mask, 32'h3);
        capture_en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_mask", dut.mask, 32'h0);
        check("en_state", dut.state, 32'h0);
        check("en_value_held", value_out, 32'h321F);
        capture_en = 1'b1;
        idle(4);

        // All anodes low: nothing selected
        fv_base = fv_cnt;
        an_n  = 4'b0000;
        seg_n = {pat[8], 1'b1};
        repeat (50) @(negedge clk);
        check("multi_state_mid", dut.state, 32'h0);
        repeat (50) @(negedge clk);
        check("multi_state", dut.state, 32'h0);
        check("multi_mask", dut.mask, 32'h0);
        check("multi_cnt", dut.cnt, 32'h0);
        check("multi_fv_count", fv_cnt - fv_base, 32'd0);
        idle(4);

        // Reset mid-frame, then a full scan
        fv_base = fv_cnt;
        show(0, 4'h9, 1'b0, 64);
        show(1, 4'h8, 1'b0, 64);
        show(2, 4'h7, 1'b0, 64);
        check("rstmid_mask_before", dut.mask, 32'h7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_mask", dut.mask, 32'h0);
        check("rstmid_value", value_out, 32'h0);
        scan(16'hDCBA, 4'b0000, 64);
        idle(4);
        check("rstmid_fv_count", fv_cnt - fv_base, 32'd1);
        check("rstmid_final_value", value_out, 32'hDCBA);
        check("rstmid_final_err", err_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Read-back monitor for the multiplexed seven-segment display bus. It samples the active-low anode and segment lines driven by the display path and inverts the hex-to-segment encoding back to nibbles. It assembles one complete scan frame into a hex word and flags undecodable patterns. It sits beside the display driver in self-test and readback builds and feeds status registers and the bench scoreboard.

## Interface
- NUM_DIGITS, 4: digits on the multiplexed bus.
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured; legal range 1..1023.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- capture_en  in  1  high enables capture; low aborts any in-progress frame.
- an_n  in  NUM_DIGITS  anode strobes, active low, one digit per bit.
- seg_n  in  8  segment lines, active low; [7]=a … [1]=g, [0]=dp.
- value_out  out  4*NUM_DIGITS  last complete frame; digit i at [4i+3:4i].
- dp_out  out  NUM_DIGITS  decimal point lit per digit in last frame.
- err_out  out  NUM_DIGITS  digit i pattern undecodable in last frame.
- frame_valid  out  1  one-cycle pulse when value_out/dp_out/err_out update.

## Operation
- an_n and seg_n are registered once (sample stage), then compared with the previous sample.
- Digit selection: exactly one an_n bit low selects that digit index. Zero or more than one bit low means no digit is selected.
- Decode of seg_n[7:1] into a nibble:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0001100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
  - Any other pattern gives nibble 0 with err set.
  - dp = ~seg_n[0], decoded independently of the nibble.
- FSM:
  - IDLE: no digit selected or capture_en low; counter = 0. Moves to SETTLE when a single digit is selected.
  - SETTLE: counter increments while the sample equals the previous sample. Any change restarts the count at 1, or returns to IDLE if no digit is selected. At counter == STABLE_CYCLES, captures into the shadow slot for that digit, sets the seen-mask bit, and moves to HELD.
  - HELD: no further capture. Any change in the sample moves to SETTLE (count 1) or to IDLE.
- Frame completion: when the seen mask is all ones, shadow → outputs, frame_valid pulses, and the mask clears. Frame completion takes priority over a simultaneous capture, which is applied after the copy into the new frame's mask.
- Same digit captured twice before frame completion: the shadow is overwritten and the mask bit stays set.
- capture_en low: mask cleared, FSM forced to IDLE, outputs retain the last frame.
- Counter width is $clog2(STABLE_CYCLES+1) and saturates; it never wraps.

## Timing
- Reset: value_out=0, dp_out=0, err_out=0, frame_valid=0, mask=0, counter=0, FSM=IDLE, sample registers cleared to all-ones (nothing lit, no digit selected).
- Input to first sample: 1 cycle.
- A digit presented stable from cycle t is captured on the edge at t+STABLE_CYCLES.
- Last digit capture at cycle c gives frame_valid high in cycle c+1, with outputs updated on the same edge.
- frame_valid is never high for two consecutive cycles.
- rst mid-frame discards partial captures. The next frame_valid requires all digits recaptured.

## Structure
- Package seven_seg_pkg: the 16 segment pattern constants (shared with the encoder side), bit-position constants for a..g/dp, and the FSM state enum.
- Sub-module seg_pattern_to_hex: combinational, 7-bit pattern in; nibble and err out.
- Top holds the sample registers, FSM, counter, shadow registers and mask.

## Test plan
- Scan 4 digits showing 1,2,3,4 with STABLE_CYCLES=16 and 64 cycles per digit. Required: value_out=16'h4321, err_out=0, dp_out=0, frame_valid one pulse per scan.
- Digit held for only 15 cycles. Required: no capture, and no frame_valid for that scan.
- Digit 2 with seg_n=8'b11111111 (blank). Required: err_out[2]=1, nibble 0; the other digits decode normally.
- seg_n[0]=0 on digit 0 with pattern F. Required: dp_out[0]=1, nibble F.
- an_n=4'b0000 (multiple anodes low) for 100 cycles. Required: FSM in IDLE, no captures.
- rst asserted after 3 digits are captured, then a full scan of A,b,C,d. Required: exactly one frame_valid with value_out=16'hDCBA.
